// File: rtl/multi_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// multi_frame_buffer_if : writer / commit / display-read bundle for the frame buffer
// Rev 1.0
// ============================================================================
interface multi_frame_buffer_if #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 13,
  parameter int TILE_SHIFT = 3,
  parameter int COORD_W    = 10
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  commit;
  logic                  wr_stall;
  logic [1:0]            wr_buf;
  logic                  new_frame;
  logic                  rd_en;
  logic [COORD_W-1:0]    rd_x;
  logic [COORD_W-1:0]    rd_y;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic [TILE_SHIFT-1:0] rd_sub_x;
  logic [TILE_SHIFT-1:0] rd_sub_y;
  logic [1:0]            disp_buf;
  logic [15:0]           drop_count;

  modport master (
    output wr_en, wr_addr, wr_data, commit, new_frame, rd_en, rd_x, rd_y,
    input  wr_stall, wr_buf, rd_valid, rd_data, rd_sub_x, rd_sub_y, disp_buf, drop_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, new_frame, rd_en, rd_x, rd_y,
    output wr_stall, wr_buf, rd_valid, rd_data, rd_sub_x, rd_sub_y, disp_buf, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/multi_frame_buffer.sv
`default_nettype none
// ============================================================================
// multi_frame_buffer : N-way (2..4) tiled frame buffer, commit/new_frame buffer rotation
// Rev 1.0
// ============================================================================
module multi_frame_buffer #(
  parameter int NUM_BUF    = 3,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 13,
  parameter int DEPTH      = 4800,
  parameter int TILE_COLS  = 80,
  parameter int TILE_SHIFT = 3,
  parameter int COORD_W    = 10
) (
  input wire logic            clk,
  input wire logic            rst_n,
  multi_frame_buffer_if.slave bus
);
  localparam int              C_MEM_AW   = $clog2(NUM_BUF * DEPTH);
  localparam logic [1:0]      C_LAST_BUF = 2'(NUM_BUF - 1);
  localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_WRITE     = 1'b0,
    S_WAIT_SWAP = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            wr_buf_q, wr_buf_d;
  logic [1:0]            disp_buf_q, disp_buf_d;
  logic [1:0]            ready_buf_q, ready_buf_d;
  logic                  ready_vld_q, ready_vld_d;
  logic [15:0]           drop_q, drop_d;
  logic                  rd_valid_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic [TILE_SHIFT-1:0] rd_sub_x_q, rd_sub_y_q;

  // All buffers share one flat array; buffer b occupies [b*DEPTH, (b+1)*DEPTH).
  logic [DATA_W-1:0]     mem_q [NUM_BUF*DEPTH];

  logic                  w_stall;
  logic                  w_wr_fire;
  logic [C_MEM_AW-1:0]   w_wr_idx;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic                  w_rd_in_range;
  logic [C_MEM_AW-1:0]   w_rd_idx;
  logic [1:0]            w_free_idx;
  logic                  w_free_found;

  assign w_stall   = (state_q == S_WAIT_SWAP);
  assign w_wr_fire = bus.wr_en && !w_stall && ({1'b0, bus.wr_addr} < C_DEPTH);
  assign w_wr_idx  = C_MEM_AW'(wr_buf_q) * C_MEM_AW'(DEPTH) + C_MEM_AW'(bus.wr_addr);

  assign w_rd_addr     = ADDR_W'(bus.rd_x >> TILE_SHIFT)
                       + ADDR_W'(bus.rd_y >> TILE_SHIFT) * ADDR_W'(TILE_COLS);
  assign w_rd_in_range = ({1'b0, w_rd_addr} < C_DEPTH);
  assign w_rd_idx      = C_MEM_AW'(disp_buf_q) * C_MEM_AW'(DEPTH) + C_MEM_AW'(w_rd_addr);

  always_comb begin
    state_d      = state_q;
    wr_buf_d     = wr_buf_q;
    disp_buf_d   = disp_buf_q;
    ready_buf_d  = ready_buf_q;
    ready_vld_d  = ready_vld_q;
    drop_d       = drop_q;
    w_free_idx   = 2'd0;
    w_free_found = 1'b0;

    if (bus.new_frame && ready_vld_q) begin
      disp_buf_d  = ready_buf_q;
      ready_vld_d = 1'b0;
    end

    if (bus.commit && state_q == S_WRITE) begin
      if (ready_vld_d && drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
      ready_buf_d = wr_buf_q;
      ready_vld_d = 1'b1;
      // Descending scan so the lowest eligible index is the one kept.
      for (int i = NUM_BUF - 1; i >= 0; i--) begin
        if (2'(i) != disp_buf_d && 2'(i) != wr_buf_q) begin
          w_free_idx   = 2'(i);
          w_free_found = 1'b1;
        end
      end
      if (w_free_found) begin
        wr_buf_d = w_free_idx;
      end else begin
        state_d = S_WAIT_SWAP;
      end
    end

    // A stalled writer only exists with a pending ready frame, so step one already flipped.
    if (state_q == S_WAIT_SWAP && bus.new_frame) begin
      wr_buf_d = disp_buf_q;
      state_d  = S_WRITE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WRITE;
      wr_buf_q    <= 2'd0;
      disp_buf_q  <= C_LAST_BUF;
      ready_buf_q <= 2'd0;
      ready_vld_q <= 1'b0;
      drop_q      <= 16'd0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_sub_x_q  <= '0;
      rd_sub_y_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_buf_q    <= wr_buf_d;
      disp_buf_q  <= disp_buf_d;
      ready_buf_q <= ready_buf_d;
      ready_vld_q <= ready_vld_d;
      drop_q      <= drop_d;
      rd_valid_q  <= bus.rd_en;
      rd_sub_x_q  <= bus.rd_x[TILE_SHIFT-1:0];
      rd_sub_y_q  <= bus.rd_y[TILE_SHIFT-1:0];
      if (bus.rd_en) begin
        rd_data_q <= w_rd_in_range ? mem_q[w_rd_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      mem_q[w_wr_idx] <= bus.wr_data;
    end
  end

  assign bus.wr_stall   = w_stall;
  assign bus.wr_buf     = wr_buf_q;
  assign bus.disp_buf   = disp_buf_q;
  assign bus.drop_count = drop_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_sub_x   = rd_sub_x_q;
  assign bus.rd_sub_y   = rd_sub_y_q;
endmodule
`default_nettype wire
